// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencing controller for the operand-entry ALU datapath.
// Captures operand A, then operand B and an opcode. Runs either a
// single-cycle ALU op or a W-cycle shift-add multiply. Holds the result and
// flags for display, and pulses clear_entry so that each entry starts from
// zero.
//
// Handshake: enter and cancel are single-cycle pulses that are sampled on
// the rising edge of hz100, and cancel wins when both are high. There is no
// back-pressure. done is a one-cycle pulse on the first SHOW cycle, and from
// that cycle on result/zero/carry/overflow are valid and held. busy is high
// for every EXEC cycle.
module alu_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           hz100,
  input  logic           reset,
  input  logic           enter,
  input  logic           cancel,
  input  logic [W-1:0]   entry_val,
  input  logic [2:0]     op_sel,
  output logic           clear_entry,
  output logic [W-1:0]   a_reg,
  output logic [W-1:0]   b_reg,
  output logic [2:0]     op_reg,
  output logic [2*W-1:0] result,
  output logic           zero,
  output logic           carry,
  output logic           overflow,
  output logic           busy,
  output logic           done,
  output logic [1:0]     state
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] ENTER_A = 2'd0;
  localparam logic [1:0] ENTER_B = 2'd1;
  localparam logic [1:0] EXEC    = 2'd2;
  localparam logic [1:0] SHOW    = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W:0]     shl_ext;   // [W] is the last bit shifted out
  logic [W:0]     shr_ext;   // [0] is the last bit shifted out
  logic [CW-1:0]  sh_amt;
  logic [2*W-1:0] alu_res;
  logic           alu_c;
  logic           alu_v;

  logic [CW-1:0]  mul_cnt;
  logic [2*W-1:0] mul_acc;
  logic [2*W-1:0] mul_partial;
  logic [2*W-1:0] mul_next;
  logic           mul_last;

  assign busy = (state == EXEC);

  // Single-cycle ALU result and flags, from the captured operands.
  always_comb begin
    sum     = {1'b0, a_reg} + {1'b0, b_reg};
    diff    = {1'b0, a_reg} - {1'b0, b_reg};
    sh_amt  = b_reg[CW-1:0];
    shl_ext = {1'b0, a_reg} << sh_amt;
    shr_ext = {a_reg, 1'b0} >> sh_amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_res = {{(W-1){1'b0}}, sum};
        alu_c   = sum[W];
        alu_v   = (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]);
      end
      OP_SUB: begin
        alu_res = {{W{1'b0}}, diff[W-1:0]};
        alu_c   = diff[W];
        alu_v   = (a_reg[W-1] != b_reg[W-1]) && (diff[W-1] != a_reg[W-1]);
      end
      OP_AND: alu_res = {{W{1'b0}}, a_reg & b_reg};
      OP_OR:  alu_res = {{W{1'b0}}, a_reg | b_reg};
      OP_XOR: alu_res = {{W{1'b0}}, a_reg ^ b_reg};
      OP_SHL: begin
        alu_res = {{W{1'b0}}, shl_ext[W-1:0]};
        alu_c   = shl_ext[W];
      end
      OP_SHR: begin
        alu_res = {{W{1'b0}}, shr_ext[W:1]};
        alu_c   = shr_ext[0];
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  // One shift-add step of the iterative multiply, indexed by mul_cnt.
  always_comb begin
    mul_partial = a_reg[mul_cnt] ? ({{W{1'b0}}, b_reg} << mul_cnt) : '0;
    mul_next    = mul_acc + mul_partial;
    mul_last    = (mul_cnt == CW'(W - 1));
  end

  // Sequencing FSM, operand/opcode capture, multiply iteration and result registers.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state       <= ENTER_A;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      result      <= '0;
      zero        <= 1'b1;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      done        <= 1'b0;
      clear_entry <= 1'b0;
      mul_cnt     <= '0;
      mul_acc     <= '0;
    end else begin
      clear_entry <= 1'b0;
      done        <= 1'b0;
      if (cancel) begin
        // Abort from anywhere; operands and the shown result stay put.
        state       <= ENTER_A;
        clear_entry <= 1'b1;
      end else begin
        case (state)
          ENTER_A: begin
            if (enter) begin
              a_reg       <= entry_val;
              clear_entry <= 1'b1;
              state       <= ENTER_B;
            end
          end
          ENTER_B: begin
            if (enter) begin
              b_reg       <= entry_val;
              op_reg      <= op_sel;
              clear_entry <= 1'b1;
              mul_acc     <= '0;
              mul_cnt     <= '0;
              state       <= EXEC;
            end
          end
          EXEC: begin
            if (op_reg == OP_MUL) begin
              if (mul_last) begin
                result   <= mul_next;
                zero     <= (mul_next == '0);
                carry    <= 1'b0;
                overflow <= |mul_next[2*W-1:W];
                done     <= 1'b1;
                state    <= SHOW;
              end else begin
                mul_acc <= mul_next;
                mul_cnt <= mul_cnt + CW'(1);
              end
            end else begin
              result   <= alu_res;
              zero     <= (alu_res == '0);
              carry    <= alu_c;
              overflow <= alu_v;
              done     <= 1'b1;
              state    <= SHOW;
            end
          end
          SHOW: begin
            if (enter) begin
              clear_entry <= 1'b1;
              state       <= ENTER_A;
            end
          end
          default: state <= ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl. A scoreboard queue holds the expected
// {result, carry, overflow, zero} for each operation. A monitor pops and
// compares it on every done pulse.
module tb_alu_seq_ctrl;

  localparam int W = 8;

  logic           hz100;
  logic           reset;
  logic           enter;
  logic           cancel;
  logic [W-1:0]   entry_val;
  logic [2:0]     op_sel;
  logic           clear_entry;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [2:0]     op_reg;
  logic [2*W-1:0] result;
  logic           zero;
  logic           carry;
  logic           overflow;
  logic           busy;
  logic           done;
  logic [1:0]     state;

  logic [2*W+2:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  alu_seq_ctrl #(.W(W)) dut (
    .hz100(hz100), .reset(reset), .enter(enter), .cancel(cancel),
    .entry_val(entry_val), .op_sel(op_sel), .clear_entry(clear_entry),
    .a_reg(a_reg), .b_reg(b_reg), .op_reg(op_reg), .result(result),
    .zero(zero), .carry(carry), .overflow(overflow), .busy(busy),
    .done(done), .state(state)
  );

  // ---------------- clock ----------------
  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Caller sits at a negedge; pulses enter for one cycle.
  task automatic press(input logic [W-1:0] val, input logic [2:0] op);
    enter     = 1'b1;
    entry_val = val;
    op_sel    = op;
    @(negedge hz100);
    enter     = 1'b0;
  endtask

  task automatic push_exp(input logic [2*W-1:0] res, input logic c, input logic v, input logic z);
    exp_q.push_back({res, c, v, z});
  endtask

  // Full A / B / EXEC / SHOW / back-to-A sequence with timing checks.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [2*W-1:0] res,
                        input logic c, input logic v);
    int k;
    int busy_cnt;
    int lat;
    press(a, 3'b000);
    check({name, "_clrA"}, {31'd0, clear_entry}, 32'd1);
    check({name, "_stA"}, {30'd0, state}, 32'd1);
    check({name, "_a"}, {24'd0, a_reg}, {24'd0, a});
    push_exp(res, c, v, (res == '0));
    press(b, op);
    check({name, "_clrB"}, {31'd0, clear_entry}, 32'd1);
    check({name, "_b"}, {24'd0, b_reg}, {24'd0, b});
    check({name, "_op"}, {29'd0, op_reg}, {29'd0, op});
    k = 0;
    busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      @(negedge hz100);
      k++;
    end
    lat = (op == 3'b111) ? W : 1;
    check({name, "_lat"}, k, lat);
    check({name, "_busy"}, busy_cnt, lat);
    if (k >= 40) exp_q.delete();
    @(negedge hz100);
    check({name, "_done1cyc"}, {31'd0, done}, 32'd0);
    check({name, "_show"}, {30'd0, state}, 32'd3);
    press(8'h00, 3'b000);
    check({name, "_back"}, {30'd0, state}, 32'd0);
    check({name, "_clrS"}, {31'd0, clear_entry}, 32'd1);
    check({name, "_keep"}, {16'd0, result}, {16'd0, res});
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_state"}, {30'd0, state}, 32'd0);
    check({name, "_a"}, {24'd0, a_reg}, 32'd0);
    check({name, "_b"}, {24'd0, b_reg}, 32'd0);
    check({name, "_op"}, {29'd0, op_reg}, 32'd0);
    check({name, "_res"}, {16'd0, result}, 32'd0);
    check({name, "_flags"}, {28'd0, zero, carry, overflow, busy}, 32'h8);
    check({name, "_pulses"}, {30'd0, done, clear_entry}, 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge hz100) begin
    logic [2*W+2:0] e;
    if (!reset && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", {16'd0, result}, {16'd0, e[2*W+2:3]});
        check("sb_flags", {29'd0, carry, overflow, zero}, {29'd0, e[2:0]});
        check("sb_state", {30'd0, state}, 32'd3);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    reset = 1'b1; enter = 1'b0; cancel = 1'b0; entry_val = '0; op_sel = '0;
    repeat (2) @(negedge hz100);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge hz100);

    run_op("add7f", 8'h7F, 8'h01, 3'b000, 16'h0080, 1'b0, 1'b1);
    run_op("sub35", 8'h03, 8'h05, 3'b001, 16'h00FE, 1'b1, 1'b0);
    run_op("sub80", 8'h80, 8'h01, 3'b001, 16'h007F, 1'b0, 1'b1);
    run_op("and",   8'hC3, 8'h5A, 3'b010, 16'h0042, 1'b0, 1'b0);
    run_op("or",    8'hC3, 8'h5A, 3'b011, 16'h00DB, 1'b0, 1'b0);
    run_op("xor",   8'hC3, 8'h5A, 3'b100, 16'h0099, 1'b0, 1'b0);
    run_op("mulff", 8'hFF, 8'hFF, 3'b111, 16'hFE01, 1'b0, 1'b1);
    run_op("mul0",  8'h00, 8'h37, 3'b111, 16'h0000, 1'b0, 1'b0);
    run_op("shl3",  8'h81, 8'h03, 3'b101, 16'h0008, 1'b0, 1'b0);
    run_op("shr3",  8'h81, 8'h03, 3'b110, 16'h0010, 1'b0, 1'b0);
    run_op("shr1",  8'h81, 8'h01, 3'b110, 16'h0040, 1'b1, 1'b0);

    // MUL with a stray enter in EXEC, then cancel at EXEC cycle 4.
    d0 = n_done;
    press(8'h05, 3'b000);
    press(8'h07, 3'b111);      // now in EXEC cycle 0
    press(8'h00, 3'b000);      // enter during EXEC, now cycle 1
    check("exec_ignore_enter", {30'd0, state}, 32'd2);
    repeat (3) @(negedge hz100);
    cancel = 1'b1;             // EXEC cycle 4
    @(negedge hz100);
    cancel = 1'b0;
    check("cancel_state", {30'd0, state}, 32'd0);
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_clr", {31'd0, clear_entry}, 32'd1);
    check("cancel_keep", {16'd0, result}, 32'h0040);
    repeat (12) @(negedge hz100);
    check("cancel_nodone", n_done - d0, 32'd0);

    // enter and cancel together in ENTER_B: cancel wins.
    press(8'h11, 3'b000);
    enter = 1'b1; cancel = 1'b1; entry_val = 8'h99; op_sel = 3'b010;
    @(negedge hz100);
    enter = 1'b0; cancel = 1'b0;
    check("both_state", {30'd0, state}, 32'd0);
    check("both_b", {24'd0, b_reg}, 32'h07);
    check("both_a", {24'd0, a_reg}, 32'h11);

    // Reset in the middle of a MUL.
    press(8'hFF, 3'b000);
    press(8'hFF, 3'b111);
    repeat (3) @(negedge hz100);
    reset = 1'b1;
    @(negedge hz100);
    check_reset_vals("midrst");
    reset = 1'b0;
    @(negedge hz100);
    run_op("add_after", 8'h10, 8'h20, 3'b000, 16'h0030, 1'b0, 1'b0);

    repeat (3) @(negedge hz100);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
